// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding and constants for the pipeline stall controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/pipe_stall_ctrl_hazard_cmp.sv
// Load-use hazard detector: the EX load writes a register the ID instruction reads.
module hazard_cmp
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             lu
);

  logic dst_live_s;
  logic rs_hit_s;
  logic rt_hit_s;

  // Writes to the zero register never produce a value, so they cannot cause a hazard.
  assign dst_live_s = (ex_rt != REG_W'(ZERO_REG));
  assign rs_hit_s   = (ex_rt == id_rs);
  assign rt_hit_s   = id_uses_rt && (ex_rt == id_rt);
  assign lu         = ex_is_load && dst_live_s && (rs_hit_s || rt_hit_s);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller with optional MDU wait and timeout handling.
// The MDU_WAIT/ERR path is built only when PIPE_MDU_EN is defined.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int CNT_W       = 16,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_is_load,
  input  logic             id_mdu_op,
  input  logic             mdu_done,
  input  logic             br_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_clr,
  output logic             idex_bubble,
  output logic             mdu_start,
  output logic             mdu_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(MDU_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

  state_t           state_r;
  state_t           state_nx;
  logic [CNT_W-1:0] stall_r;
  logic             lu_s;
  logic             stall_s;

`ifdef PIPE_MDU_EN
  logic [CNT_W-1:0] wait_r;
  logic [CNT_W-1:0] wait_nx;
`else
  logic unused_s;
  assign unused_s = &{1'b0, id_mdu_op, mdu_done, TO_LAST};
`endif

  hazard_cmp #(
    .REG_W(REG_W)
  ) u_hazard_cmp (
    .ex_is_load (ex_is_load),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .lu         (lu_s)
  );

  // Next-state decode and combinational pipeline control.
  always_comb begin
    state_nx  = state_r;
    stall_s   = 1'b0;
    ifid_clr  = 1'b0;
    mdu_start = 1'b0;
`ifdef PIPE_MDU_EN
    wait_nx   = wait_r;
`endif
    if (!clrn) begin
      stall_s = 1'b1;
    end else begin
      case (state_r)
        RUN: begin
          if (lu_s) begin
            // The stalled instruction is replayed next cycle, so its branch/MDU request waits too.
            stall_s = 1'b1;
          end else begin
            ifid_clr = br_taken;
`ifdef PIPE_MDU_EN
            if (id_mdu_op) begin
              mdu_start = 1'b1;
              state_nx  = MDU_WAIT;
              wait_nx   = {CNT_W{1'b0}};
            end else begin
              state_nx  = RUN;
            end
`endif
          end
        end
`ifdef PIPE_MDU_EN
        MDU_WAIT: begin
          stall_s = 1'b1;
          if (mdu_done) begin
            state_nx = RUN;
          end else if (wait_r == TO_LAST) begin
            state_nx = ERR;
          end else begin
            wait_nx  = wait_r + CNT_W'(1);
          end
        end
        ERR: begin
          stall_s = 1'b1;
        end
`endif
        default: begin
          stall_s  = 1'b1;
          state_nx = RUN;
        end
      endcase
    end
  end

  assign pc_we       = !stall_s;
  assign ifid_we     = !stall_s;
  assign idex_bubble = stall_s;
  assign stall_cnt   = stall_r;
  assign state       = state_r;

`ifdef PIPE_MDU_EN
  assign mdu_err = (state_r == ERR);
`else
  assign mdu_err = 1'b0;
`endif

  // State register and saturating stall counter.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r <= RUN;
      stall_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nx;
      if (stall_s && (stall_r != STALL_MAX)) begin
        stall_r <= stall_r + CNT_W'(1);
      end else begin
        stall_r <= stall_r;
      end
    end
  end

`ifdef PIPE_MDU_EN
  // MDU wait-cycle counter.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wait_r <= {CNT_W{1'b0}};
    end else begin
      wait_r <= wait_nx;
    end
  end
`endif

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter REG_W, default 5: register-specifier width.
REQ-002 Parameter CNT_W, default 16: stall-counter width.
REQ-003 Parameter MDU_TIMEOUT, default 64: maximum number of MDU_WAIT cycles before an error is declared; legal range 2..2^CNT_W-1.
REQ-004 Port clk, input, 1: clock; all state updates on its rising edge.
REQ-005 Port clrn, input, 1: reset, asynchronous, active-low.
REQ-006 Port id_rs / id_rt, input, REG_W each: source registers of the instruction in ID.
REQ-007 Port id_uses_rt, input, 1: the ID instruction reads rt.
REQ-008 Port ex_rt, input, REG_W: destination register of the instruction in EX.
REQ-009 Port ex_is_load, input, 1: the EX instruction is a load.
REQ-010 Port id_mdu_op, input, 1: the ID instruction is a multiply/divide.
REQ-011 Port mdu_done, input, 1: single-cycle completion pulse from the MDU.
REQ-012 Port br_taken, input, 1: branch/jump resolved taken in ID.
REQ-013 Port pc_we / ifid_we, output, 1 each: enables for the PC and IF/ID pipeline registers.
REQ-014 Port ifid_clr, output, 1: synchronous flush of IF/ID.
REQ-015 Port idex_bubble, output, 1: load NOP into ID/EX.
REQ-016 Port mdu_start, output, 1: single-cycle MDU start pulse.
REQ-017 Port mdu_err, output, 1: sticky MDU timeout flag.
REQ-018 Port stall_cnt, output, CNT_W: count of stalled cycles.
REQ-019 Port state, output, 2: current FSM state, for debug.

Function
REQ-020 The FSM SHALL have the states RUN=0, MDU_WAIT=1 and ERR=2; encoding 3 is illegal and SHALL recover to RUN on the next edge.
REQ-021 A load-use hazard (lu) SHALL be ex_is_load && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
REQ-022 In RUN with lu=1, the block SHALL drive pc_we=0, ifid_we=0 and idex_bubble=1 in the same cycle (combinational); the state SHALL stay RUN and id_mdu_op/br_taken SHALL be ignored that cycle.
REQ-023 In RUN with lu=0 and id_mdu_op=1, the block SHALL drive mdu_start=1 for exactly that cycle with the pipeline not stalled, and SHALL enter MDU_WAIT.
REQ-024 In RUN with lu=0 and br_taken=1, the block SHALL drive ifid_clr=1 that cycle with pc_we=ifid_we=1; this occurs in the same cycle as mdu_start when id_mdu_op is also 1.
REQ-025 In MDU_WAIT, the block SHALL drive pc_we=ifid_we=0, idex_bubble=1, ifid_clr=0 and mdu_start=0; br_taken and lu SHALL be ignored.
REQ-026 In MDU_WAIT with mdu_done=1, the stall SHALL still hold that cycle and the next state SHALL be RUN; mdu_done in any other state SHALL be ignored.
REQ-027 The wait counter SHALL clear on entry to MDU_WAIT and increment each MDU_WAIT cycle; when it reaches MDU_TIMEOUT-1 without mdu_done, the next state SHALL be ERR; mdu_done in that same cycle SHALL win (next state RUN).
REQ-028 ERR SHALL be terminal until reset, with pc_we=ifid_we=0, idex_bubble=1 and mdu_err=1.
REQ-029 stall_cnt SHALL increment on every cycle with pc_we=0 and SHALL saturate at 2^CNT_W-1.
REQ-030 In RUN with no event, the outputs SHALL be pc_we=ifid_we=1 and all other control outputs 0.

Reset
REQ-031 While clrn=0, the block SHALL drive state=RUN, wait counter=0, stall_cnt=0, mdu_err=0, pc_we=ifid_we=0, idex_bubble=1 and ifid_clr=mdu_start=0, asynchronously.
REQ-032 Reset asserted mid-MDU_WAIT SHALL abandon the wait; a late mdu_done after release SHALL be ignored in RUN.

Configuration
REQ-033 With PIPE_MDU_EN defined, the MDU_WAIT and ERR logic SHALL be present.
REQ-034 With PIPE_MDU_EN undefined, id_mdu_op and mdu_done SHALL be ignored, mdu_start=0 and mdu_err=0 constant, and state SHALL never leave RUN; the ports SHALL remain.

Structure
REQ-035 Package pipe_ctrl_pkg SHALL hold the state enum (RUN, MDU_WAIT, ERR) and the constant ZERO_REG=0.
REQ-036 The load-use comparator SHALL be the sub-module hazard_cmp (purely combinational); the FSM and counters SHALL be in pipe_stall_ctrl.

Verification
REQ-037 Scenario: ex_is_load=1, ex_rt=5, id_rs=5 for 1 cycle -> pc_we=0, ifid_we=0, idex_bubble=1 that cycle, stall_cnt=1.
REQ-038 Scenario: ex_is_load=1, ex_rt=0, id_rs=0 -> no stall, pc_we=1.
REQ-039 Scenario: id_mdu_op=1 in RUN, mdu_done on wait cycle 10 -> mdu_start one cycle, 11 stalled cycles, then RUN, stall_cnt=11.
REQ-040 Scenario: MDU_TIMEOUT=4, no mdu_done -> ERR after 4 wait cycles, mdu_err=1 until clrn pulse.
REQ-041 Scenario: br_taken=1 with lu=1 -> ifid_clr=0; the next cycle br_taken=1, lu=0 -> ifid_clr=1.
REQ-042 Scenario: clrn low for 1 cycle during MDU_WAIT -> state=RUN and stall_cnt=0 immediately; mdu_done=1 after release -> no effect.
